// File: rtl/pos_edge_det_sync_chain.sv
// N-flop level synchroniser for bringing asynchronous inputs into the clk domain.
// Every stage resets to the same value so no X leaves the chain after reset.
module sync_chain #(
    parameter int WIDTH   = 1,
    parameter int STAGES  = 2,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] RST_WORD = (RST_VAL != 0) ? '1 : '0;

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {STAGES{RST_WORD}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/pos_edge_det.sv
// Per-bit rising/falling/any-edge pulse generator with optional input
// synchroniser and optional registered outputs.
module pos_edge_det #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter int REG_OUT     = 0,
    parameter int RST_HIST    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] pe,
    output logic [WIDTH-1:0] ne,
    output logic [WIDTH-1:0] edge_o
);

    localparam logic [WIDTH-1:0] HIST_RST = (RST_HIST != 0) ? '1 : '0;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;
    logic [WIDTH-1:0] pe_d;
    logic [WIDTH-1:0] ne_d;
    logic [WIDTH-1:0] edge_d;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            sync_chain #(
                .WIDTH  (WIDTH),
                .STAGES (SYNC_STAGES),
                .RST_VAL(RST_HIST)
            ) u_sync (
                .clk  (clk),
                .rst_n(rst_n),
                .d    (sig),
                .q    (s)
            );
        end else begin : g_nosync
            assign s = sig;
        end
    endgenerate

    always_comb begin
        hist_d = s;
        pe_d   = s & ~hist_q;
        ne_d   = ~s & hist_q;
        edge_d = s ^ hist_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= HIST_RST;
        end else begin
            hist_q <= hist_d;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] pe_q;
            logic [WIDTH-1:0] ne_q;
            logic [WIDTH-1:0] edge_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pe_q   <= '0;
                    ne_q   <= '0;
                    edge_q <= '0;
                end else begin
                    pe_q   <= pe_d;
                    ne_q   <= ne_d;
                    edge_q <= edge_d;
                end
            end

            assign pe     = pe_q;
            assign ne     = ne_q;
            assign edge_o = edge_q;
        end else begin : g_comb_out
            // Gate with rst_n so the pulses vanish the instant reset asserts.
            assign pe     = rst_n ? pe_d   : '0;
            assign ne     = rst_n ? ne_d   : '0;
            assign edge_o = rst_n ? edge_d : '0;
        end
    endgenerate

endmodule

// File: tb/tb_pos_edge_det.sv
// Scoreboard bench for pos_edge_det: four configurations share clk and rst_n;
// expectations are queued at drive time and popped at each negedge sample.
module tb_pos_edge_det;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sig0 = 1'b1;
    logic [3:0] sig4 = 4'b0;
    logic       sigl = 1'b0;
    logic       sigh = 1'b0;

    logic       pe0, ne0, ed0;
    logic [3:0] pe4, ne4, ed4;
    logic       pel, nel, edl;
    logic       peh, neh, edh;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic       pe0, ne0, ed0;
        logic [3:0] pe4, ne4, ed4;
        logic       peh, neh, edh;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] lat_q[$];

    // Reference history of what each configuration's edge detector last captured
    logic       m0, mh, pl;
    logic [3:0] m4;

    always #5 clk = ~clk;

    pos_edge_det #(.WIDTH(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .sig(sig0), .pe(pe0), .ne(ne0), .edge_o(ed0));
    pos_edge_det #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sig(sig4), .pe(pe4), .ne(ne4), .edge_o(ed4));
    pos_edge_det #(.WIDTH(1), .SYNC_STAGES(2), .REG_OUT(1)) dutl (
        .clk(clk), .rst_n(rst_n), .sig(sigl), .pe(pel), .ne(nel), .edge_o(edl));
    pos_edge_det #(.WIDTH(1), .RST_HIST(1)) duth (
        .clk(clk), .rst_n(rst_n), .sig(sigh), .pe(peh), .ne(neh), .edge_o(edh));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    task automatic cycle(input logic rst_v, input logic n0, input logic [3:0] n4,
                         input logic nl, input logic nh);
        exp_t       e;
        logic [2:0] el;
        @(posedge clk);
        if (rst_n) begin
            m0 = sig0; m4 = sig4; mh = sigh;
        end else begin
            m0 = 1'b0; m4 = 4'b0; mh = 1'b1;
        end
        #1;
        rst_n = rst_v; sig0 = n0; sig4 = n4; sigl = nl; sigh = nh;
        if (rst_v) begin
            e.pe0 = n0 & ~m0;  e.ne0 = ~n0 & m0;  e.ed0 = n0 ^ m0;
            e.pe4 = n4 & ~m4;  e.ne4 = ~n4 & m4;  e.ed4 = n4 ^ m4;
            e.peh = nh & ~mh;  e.neh = ~nh & mh;  e.edh = nh ^ mh;
            exp_q.push_back(e);
            lat_q.push_back({nl & ~pl, ~nl & pl, nl ^ pl});
            pl = nl;
        end else begin
            lat_q.delete();
            repeat (3) lat_q.push_back(3'b000);
            pl = 1'b0;
        end
        @(negedge clk);
        cyc++;
        if (rst_v) begin
            e  = exp_q.pop_front();
            el = lat_q.pop_front();
        end else begin
            e  = '0;
            el = 3'b000;
        end
        $display("cyc %0d rst_n=%0b sig0=%0b sig4=%b sigl=%0b sigh=%0b | pe0=%0b pe4=%b pel=%0b neh=%0b",
                 cyc, rst_n, sig0, sig4, sigl, sigh, pe0, pe4, pel, neh);
        check_eq("pe0", pe0, e.pe0);  check_eq("ne0", ne0, e.ne0);  check_eq("ed0", ed0, e.ed0);
        check_eq("pe4", pe4, e.pe4);  check_eq("ne4", ne4, e.ne4);  check_eq("ed4", ed4, e.ed4);
        check_eq("peh", peh, e.peh);  check_eq("neh", neh, e.neh);  check_eq("edh", edh, e.edh);
        check_eq("pel", pel, el[2]);  check_eq("nel", nel, el[1]);  check_eq("edl", edl, el[0]);
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_pe0", pe0, 0);
        check_eq("async_ed0", ed0, 0);
        check_eq("async_pel", pel, 0);
        check_eq("async_edl", edl, 0);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        m0 = 1'b0; m4 = 4'b0; mh = 1'b1; pl = 1'b0;
        #1;
        check_eq("rst_pe0", pe0, 0);
        check_eq("rst_neh", neh, 0);

        // Held in reset with sig0 high and sigh low: all outputs quiet
        cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        // Release: sig0 high gives one pe, sigh low gives one ne on the RST_HIST=1 copy
        cycle(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);

        // Fall on sig0, alternating pattern on the 4-bit copy, rise on the latency copy
        cycle(1'b1, 1'b0, 4'b1010, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 4'b0101, 1'b1, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, 4'b0101, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 4'b0101, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 4'b0101, 1'b0, 1'b0);

        // Toggle every cycle: pe/ne alternate while edge stays high
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'(i % 2 == 0), (i % 2 == 0) ? 4'b1111 : 4'b0000,
                  1'(i % 2 == 0), 1'(i % 2 == 1));
        end

        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Line up a pe on dut0 and the delayed pe on dutl, then reset mid-pulse
        repeat (2) cycle(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
        mid_reset();
        cycle(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);

        // Steady levels: no further pulses
        repeat (50) cycle(1'b1, 1'b1, 4'b1100, 1'b1, 1'b1);
        repeat (20) cycle(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
